// File: rtl/fx_pkg.sv
// Shared types and default widths for the fixed-point multiplier datapath.
package fx_pkg;
  typedef enum logic {RND_TRUNC = 1'b0, RND_HALF_UP = 1'b1} round_mode_e;

  localparam int FX_IN_W  = 16;
  localparam int FX_FRAC  = 8;
  localparam int FX_OUT_W = 24;
endpackage

// File: rtl/fx_mul_lane.sv
// One lane: signed multiply, optional half-up round, arithmetic shift, range check.
// FX_MUL_SAT_EN clamps out-of-range results instead of wrapping.
module fx_mul_lane import fx_pkg::*; #(
  parameter int IN_W  = FX_IN_W,
  parameter int FRAC  = FX_FRAC,
  parameter int OUT_W = FX_OUT_W
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  round_mode_e             mode,
  output logic        [OUT_W-1:0] p,
  output logic                    ovf
);
  localparam int PW = 2*IN_W;
  localparam int QW = PW + 1;

  logic signed [PW-1:0]    full;
  logic signed [QW-1:0]    rterm, rnd, q;
  logic        [QW-OUT_W:0] hi;

  assign full = a * b;

  generate
    if (FRAC == 0) begin : g_nornd
      assign rterm = '0;
    end else begin : g_rnd
      assign rterm = (mode == RND_HALF_UP) ? ({{(QW-1){1'b0}}, 1'b1} << (FRAC-1)) : '0;
    end
  endgenerate

  // One guard bit keeps the rounding add from overflowing.
  assign rnd = {full[PW-1], full} + rterm;
  assign q   = rnd >>> FRAC;

  // Representable only if every bit from the output sign bit up is a copy of it.
  assign hi  = q[QW-1:OUT_W-1];
  assign ovf = ~(&hi | ~|hi);

`ifdef FX_MUL_SAT_EN
  assign p = !ovf      ? q[OUT_W-1:0] :
             q[QW-1]   ? {1'b1, {(OUT_W-1){1'b0}}} :
                         {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign p = q[OUT_W-1:0];
`endif
endmodule

// File: rtl/fx_mul_pipe.sv
// Multi-lane signed fixed-point multiplier, 2 register stages with valid/ready backpressure.
// Build with FX_MUL_SAT_EN to saturate overflowing lanes instead of wrapping.
module fx_mul_pipe import fx_pkg::*; #(
  parameter int IN_W  = FX_IN_W,
  parameter int FRAC  = FX_FRAC,
  parameter int OUT_W = FX_OUT_W,
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_a,
  input  logic [LANES*IN_W-1:0]  in_b,
  input  logic                   in_round,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_p,
  output logic [LANES-1:0]       out_ovf
);
  localparam int STAGES = 2;

  generate
    if (OUT_W > 2*IN_W+1-FRAC) begin : g_bad_outw
      $error("fx_mul_pipe: OUT_W exceeds 2*IN_W+1-FRAC");
    end
    if (FRAC >= 2*IN_W) begin : g_bad_frac
      $error("fx_mul_pipe: FRAC must be below 2*IN_W");
    end
    if (LANES < 1) begin : g_bad_lanes
      $error("fx_mul_pipe: LANES must be at least 1");
    end
  endgenerate

  logic                        adv, acc;
  logic [STAGES:1]             vld_pipe;
  logic [LANES-1:0][IN_W-1:0]  a_in, b_in, a_q, b_q;
  round_mode_e                 mode_q;
  logic [LANES-1:0][OUT_W-1:0] p_d, p_q;
  logic [LANES-1:0]            ovf_d, ovf_q;

  assign a_in      = in_a;
  assign b_in      = in_b;
  assign out_valid = vld_pipe[STAGES];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign acc       = in_valid & adv;

  // Whole pipe freezes on a stall; bubbles travel with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= RND_TRUNC;
    end else if (adv && acc) begin
      a_q    <= a_in;
      b_q    <= b_in;
      mode_q <= round_mode_e'(in_round);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fx_mul_lane #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) u_lane (
      .a    (a_q[i]),
      .b    (b_q[i]),
      .mode (mode_q),
      .p    (p_d[i]),
      .ovf  (ovf_d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      ovf_q <= '0;
    end else if (adv && vld_pipe[1]) begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_p   = p_q;
  assign out_ovf = ovf_q;
endmodule

// File: tb/tb_fx_mul_pipe.sv
// Directed checks for fx_mul_pipe: default, narrow-output and 4-lane builds.
module tb_fx_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // default build
  logic        d_in_valid = 0, d_in_ready, d_round = 0, d_out_valid, d_out_ready = 1;
  logic [15:0] d_a = '0, d_b = '0;
  logic [23:0] d_p;
  logic [0:0]  d_ovf;

  // OUT_W = 16 build
  logic        o_in_valid = 0, o_in_ready, o_out_valid;
  logic [15:0] o_a = '0, o_b = '0, o_p;
  logic [0:0]  o_ovf;

  // LANES = 4 build
  logic        l_in_valid = 0, l_in_ready, l_out_valid;
  logic [63:0] l_a = '0, l_b = '0;
  logic [95:0] l_p;
  logic [3:0]  l_ovf;

  fx_mul_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_a), .in_b(d_b), .in_round(d_round), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_p(d_p), .out_ovf(d_ovf)
  );

  fx_mul_pipe #(.OUT_W(16)) u_o16 (
    .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .in_a(o_a), .in_b(o_b), .in_round(1'b0), .out_valid(o_out_valid),
    .out_ready(1'b1), .out_p(o_p), .out_ovf(o_ovf)
  );

  fx_mul_pipe #(.LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_a), .in_b(l_b), .in_round(1'b0), .out_valid(l_out_valid),
    .out_ready(1'b1), .out_p(l_p), .out_ovf(l_ovf)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (d_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", d_out_valid); else passed++;
    total++; if (d_p !== 24'h0) $display("FAIL reset_p: got %h expected 000000", d_p); else passed++;
    total++; if (d_ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", d_ovf); else passed++;
    total++; if (d_in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", d_in_ready); else passed++;
    rst = 1'b0;
  endtask

  // drive one set on the default build and check 2-cycle latency and result
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                         input logic [23:0] exp_p, input string name);
    @(negedge clk);
    d_in_valid = 1; d_a = a; d_b = b; d_round = rnd;
    @(negedge clk);
    d_in_valid = 0;
    total++; if (d_out_valid !== 1'b0) $display("FAIL %s_early_valid: got %b expected 0", name, d_out_valid); else passed++;
    @(negedge clk);
    total++; if (d_out_valid !== 1'b1) $display("FAIL %s_valid: got %b expected 1", name, d_out_valid); else passed++;
    total++; if (d_p !== exp_p) $display("FAIL %s_p: got %h expected %h", name, d_p, exp_p); else passed++;
    total++; if (d_ovf !== 1'b0) $display("FAIL %s_ovf: got %b expected 0", name, d_ovf); else passed++;
  endtask

  task automatic test_basic();
    run_one(16'hAA5A, 16'h4AF0, 1'b0, 24'hE6EDB8, "basic_trunc");
    run_one(16'hAA5A, 16'h4AF0, 1'b1, 24'hE6EDB8, "basic_round");
  endtask

  task automatic test_rounding();
    run_one(16'h0180, 16'h0081, 1'b0, 24'h0000C1, "rnd_trunc");
    run_one(16'h0180, 16'h0081, 1'b1, 24'h0000C2, "rnd_halfup");
  endtask

  task automatic test_overflow();
    logic [15:0] exp_p;
`ifdef FX_MUL_SAT_EN
    exp_p = 16'h7FFF;
`else
    exp_p = 16'hFF00;
`endif
    @(negedge clk);
    o_in_valid = 1; o_a = 16'h7FFF; o_b = 16'h7FFF;
    @(negedge clk);
    o_in_valid = 0;
    @(negedge clk);
    total++; if (o_out_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", o_out_valid); else passed++;
    total++; if (o_ovf !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", o_ovf); else passed++;
    total++; if (o_p !== exp_p) $display("FAIL ovf_p: got %h expected %h", o_p, exp_p); else passed++;
  endtask

  task automatic test_lanes();
    logic [95:0] exp_p;
    exp_p = {24'hFF8000, 24'h000040, 24'hFFFF00, 24'h000200};
    @(negedge clk);
    l_in_valid = 1;
    l_a = {16'h8000, 16'h0080, 16'hFF00, 16'h0100};
    l_b = {16'h0100, 16'h0080, 16'h0100, 16'h0200};
    @(negedge clk);
    l_in_valid = 0;
    @(negedge clk);
    total++; if (l_out_valid !== 1'b1) $display("FAIL lanes_valid: got %b expected 1", l_out_valid); else passed++;
    total++; if (l_p !== exp_p) $display("FAIL lanes_p: got %h expected %h", l_p, exp_p); else passed++;
    total++; if (l_ovf !== 4'h0) $display("FAIL lanes_ovf: got %h expected 0", l_ovf); else passed++;
  endtask

  // 8 sets of (k+1.0)*3.0 while out_ready runs 1,0,0,1,0,0,...
  task automatic test_backpressure();
    int sent = 0, recv = 0, cyc = 0;
    logic [23:0] held = '0;
    logic [23:0] exp_p;
    bit stall = 0;
    @(negedge clk);
    while (recv < 8 && cyc < 200) begin
      d_out_ready = (cyc % 3 == 0);
      d_in_valid  = (sent < 8);
      d_a = 16'((sent + 1) << 8); d_b = 16'h0300; d_round = 0;
      #1;
      if (stall) begin
        total++; if (d_out_valid !== 1'b1 || d_p !== held)
          $display("FAIL bp_hold: got v=%b p=%h expected v=1 p=%h", d_out_valid, d_p, held); else passed++;
      end
      total++; if (d_in_ready !== !(d_out_valid && !d_out_ready))
        $display("FAIL bp_ready: got %b expected %b", d_in_ready, !(d_out_valid && !d_out_ready)); else passed++;
      if (d_out_valid && d_out_ready) begin
        exp_p = 24'((recv + 1) * 768);
        total++; if (d_p !== exp_p) $display("FAIL bp_data%0d: got %h expected %h", recv, d_p, exp_p); else passed++;
        recv++;
      end
      stall = d_out_valid && !d_out_ready;
      held  = d_p;
      if (d_in_valid && d_in_ready) sent++;
      cyc++;
      @(negedge clk);
    end
    total++; if (recv != 8) $display("FAIL bp_count: got %0d expected 8", recv); else passed++;
    d_in_valid = 0; d_out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      total++; if (d_out_valid !== 1'b0) $display("FAIL bp_extra: got %b expected 0", d_out_valid); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_out_ready = 1;
    d_in_valid = 1; d_a = 16'hAA5A; d_b = 16'h4AF0; d_round = 0;
    @(negedge clk);
    d_a = 16'h0100; d_b = 16'h0500;
    @(posedge clk); #1;
    d_in_valid = 0;
    total++; if (d_out_valid !== 1'b1) $display("FAIL rm_pre_valid: got %b expected 1", d_out_valid); else passed++;
    rst = 1'b1;
    #1;
    total++; if (d_out_valid !== 1'b0) $display("FAIL rm_valid: got %b expected 0", d_out_valid); else passed++;
    total++; if (d_p !== 24'h0) $display("FAIL rm_p: got %h expected 000000", d_p); else passed++;
    total++; if (d_ovf !== 1'b0) $display("FAIL rm_ovf: got %b expected 0", d_ovf); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++; if (d_out_valid !== 1'b0) $display("FAIL rm_stale: got %b expected 0", d_out_valid); else passed++;
    end
    run_one(16'h0180, 16'h0081, 1'b1, 24'h0000C2, "rm_post");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_lanes();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fx_mul_pipe.md
Name: fx_mul_pipe

Overview:
- Parametrised, pipelined, multi-lane signed fixed-point multiplier for the sensor-feature datapath (normalisation scaling, weight multiply).
- Generalises the Q8.8 × Q8.8 → 24-bit truncating multiply. Adds configurable widths and fractional bits, LANES parallel channels, a selectable rounding mode, an overflow flag, and a valid/ready handshake with backpressure.

Parameters:
- IN_W, 16, operand width (signed two's complement)
- FRAC, 8, fractional bits of each operand and of the result
- OUT_W, 24, result width (signed)
- LANES, 1, number of independent parallel multiplier lanes

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  LANES*IN_W  lane i operand A at [i*IN_W +: IN_W]
- in_b  in  LANES*IN_W  lane i operand B, same packing
- in_round  in  1  0 = truncate (floor), 1 = round half up; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_p  out  LANES*OUT_W  lane i result at [i*OUT_W +: OUT_W]
- out_ovf  out  LANES  lane i result not representable in OUT_W

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Pipeline: 2 register stages.
  - S1 registers operands and the round bit.
  - S2 registers the final result and overflow flag.
  - Latency is exactly 2 cycles from an accepted input to out_valid, with no stalls.
- Stall rule: adv = out_ready | ~out_valid; in_ready = adv.
  - Stages shift only when adv = 1; bubbles are not collapsed.
  - An input is accepted when in_valid & in_ready.
  - S1.valid <= in_valid & in_ready on adv.
- Output stability: while out_valid = 1 and out_ready = 0, out_p and out_ovf hold stable.
- Arithmetic, per lane:
  - full = signed(a) * signed(b), 2*IN_W bits.
  - rnd = full + (in_round ? 2^(FRAC-1) : 0), computed in 2*IN_W+1 bits.
  - q = rnd >>> FRAC (arithmetic shift).
  - out_p = q[OUT_W-1:0].
  - out_ovf = 1 when q is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], else 0.
- FRAC = 0: the round term is 0 regardless of in_round.
- Reset values: out_valid = 0, out_p = 0, out_ovf = 0, S1.valid = 0, in_ready = 1.
- Reset mid-operation: all in-flight data is discarded; no result is emitted for operands accepted before rst.
- Simultaneous accept and emit: accepting new input and emitting a result in the same cycle is legal and gives full throughput of 1 set per cycle.
- Parameter checks (elaboration-time assertions):
  - OUT_W <= 2*IN_W+1-FRAC
  - FRAC < 2*IN_W
  - LANES >= 1

Optional Feature:
- Macro: FX_MUL_SAT_EN.
- Defined: when out_ovf = 1, out_p saturates to 2^(OUT_W-1)-1 if q > 0, or to -2^(OUT_W-1) if q < 0. out_ovf is still reported.
- Undefined: out_p wraps to q[OUT_W-1:0]; out_ovf is still reported.

Decomposition:
- Shared package fx_pkg:
  - round_mode_e enum {RND_TRUNC = 0, RND_HALF_UP = 1}
  - default width constants FX_IN_W = 16, FX_FRAC = 8, FX_OUT_W = 24
- Sub-module fx_mul_lane: one lane's combinational multiply / round / shift / overflow (and saturation).
  - Instantiated LANES times between the S1 and S2 registers.
  - The handshake and valid pipeline live only in the top module.

Test Plan:
- Defaults, LANES = 1, round = 0: a = 0xAA5A (-0x55A6), b = 0x4AF0 -> after 2 cycles out_p = 0xE6EDB8 (-6418.28125), out_ovf = 0. Same result with round = 1.
- Rounding: a = 0x0180, b = 0x0081.
  - round = 0 -> out_p = 0x0000C1.
  - round = 1 -> out_p = 0x0000C2.
- OUT_W = 16, a = b = 0x7FFF -> q = 0x3FFF00, out_ovf = 1.
  - With FX_MUL_SAT_EN, out_p = 0x7FFF; without it, out_p = 0xFF00.
- LANES = 4, lanes fed (0x0100, 0x0200), (0xFF00, 0x0100), (0x0080, 0x0080), (0x8000, 0x0100) -> out_p lanes = 0x000200, 0xFFFF00, 0x000040, 0xFF8000.
- Backpressure: stream 8 sets with in_valid = 1 while out_ready is toggled 1,0,0,1,...
  - All 8 results appear in order, none lost or duplicated.
  - Outputs hold while stalled.
  - in_ready = 0 exactly when out_valid & ~out_ready.
- Reset mid-operation: assert rst one cycle after accepting a set -> out_valid, out_p and out_ovf are 0 immediately (asynchronous).
  - No stale result after release.
  - The first post-reset input yields a result 2 cycles later.
